// File: rtl/iq_sample_fifo.sv
// IQ sample FIFO between the DDC output and the MCU bus interface.
// Stores {I,Q} pairs, pops with one-cycle latency, and reports level and sticky error status.
module iq_sample_fifo #(
  parameter int DEPTH       = 64,
  parameter int AW          = 6,
  parameter int READY_LEVEL = 16
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic signed [15:0] in_I,
  input  logic signed [15:0] in_Q,
  input  logic               in_valid,
  input  logic               rd_req,
  input  logic               flush,
  input  logic               flag_clear,
  output logic signed [15:0] out_I,
  output logic signed [15:0] out_Q,
  output logic               out_valid,
  output logic [AW:0]        level,
  output logic               empty,
  output logic               full,
  output logic               data_ready,
  output logic               overflow,
  output logic               underflow,
  output logic [7:0]         drop_cnt
);

  // Handshake: in_valid and rd_req are single-cycle strobes with no back-pressure.
  // full/empty are advisory; a strobe issued against them is recorded as a drop or
  // an underflow instead of stalling. out_valid pulses one cycle after an accepted pop.

  localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] READY_LVL = (AW+1)'(READY_LEVEL);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic wr_en;
  logic rd_en;
  logic drop_ev;
  logic unf_ev;

  assign empty      = (level == '0);
  assign full       = (level == FULL_LVL);
  assign data_ready = (level >= READY_LVL);

  // A pop against a full FIFO frees a slot, so a concurrent write is accepted.
  assign rd_en   = rd_req & ~flush & ~empty;
  assign wr_en   = in_valid & ~flush & (~full | rd_req);
  assign drop_ev = in_valid & ~flush & full & ~rd_req;
  assign unf_ev  = rd_req & ~flush & empty;

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr] <= {in_I, in_Q};
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_I     <= '0;
      out_Q     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_en;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_ptr         <= rd_ptr + AW'(1);
        {out_I, out_Q} <= mem[rd_ptr];
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Events in the same cycle as flag_clear win over the clear.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (drop_ev)         overflow <= 1'b1;
      else if (flag_clear) overflow <= 1'b0;

      if (unf_ev)          underflow <= 1'b1;
      else if (flag_clear) underflow <= 1'b0;

      if (flag_clear)                      drop_cnt <= drop_ev ? 8'd1 : 8'd0;
      else if (drop_ev && drop_cnt != '1)  drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_iq_sample_fifo.sv
// Directed bench for iq_sample_fifo: ordering, overflow/underflow flags, flush and async reset.
module tb_iq_sample_fifo;

  logic               clk_in = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [15:0] in_I = '0;
  logic signed [15:0] in_Q = '0;
  logic               in_valid = 1'b0;
  logic               rd_req = 1'b0;
  logic               flush = 1'b0;
  logic               flag_clear = 1'b0;
  logic signed [15:0] out_I;
  logic signed [15:0] out_Q;
  logic               out_valid;
  logic [6:0]         level;
  logic               empty;
  logic               full;
  logic               data_ready;
  logic               overflow;
  logic               underflow;
  logic [7:0]         drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  iq_sample_fifo #(.DEPTH(64), .AW(6), .READY_LEVEL(16)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .in_I(in_I), .in_Q(in_Q),
    .in_valid(in_valid), .rd_req(rd_req), .flush(flush), .flag_clear(flag_clear),
    .out_I(out_I), .out_Q(out_Q), .out_valid(out_valid), .level(level),
    .empty(empty), .full(full), .data_ready(data_ready), .overflow(overflow),
    .underflow(underflow), .drop_cnt(drop_cnt)
  );

  always #5 clk_in = ~clk_in;

  // Drivers: inputs change 1 ns after a rising edge and are sampled at the next one.
  task automatic push(input logic signed [15:0] i, input logic signed [15:0] q);
    in_I = i; in_Q = q; in_valid = 1'b1;
    @(posedge clk_in); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop();
    rd_req = 1'b1;
    @(posedge clk_in); #1;
    rd_req = 1'b0;
  endtask

  task automatic push_pop(input logic signed [15:0] i, input logic signed [15:0] q);
    in_I = i; in_Q = q; in_valid = 1'b1; rd_req = 1'b1;
    @(posedge clk_in); #1;
    in_valid = 1'b0; rd_req = 1'b0;
  endtask

  task automatic pulse_clear();
    flag_clear = 1'b1;
    @(posedge clk_in); #1;
    flag_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(2);
    n_vec++; if (level !== 7'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_vec++; if (empty !== 1'b1 || full !== 1'b0 || data_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_status got e/f/r=%b%b%b exp=100", empty, full, data_ready); end
    n_vec++; if (out_valid !== 1'b0 || out_I !== 16'sd0 || out_Q !== 16'sd0) begin
      n_err++; $display("FAIL reset_out got v=%b I=%0d Q=%0d exp v=0 I=0 Q=0", out_valid, out_I, out_Q); end
    n_vec++; if (overflow !== 1'b0 || underflow !== 1'b0 || drop_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_flags got o=%b u=%b d=%0d exp 0/0/0", overflow, underflow, drop_cnt); end
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    logic signed [15:0] ei;
    push(16'sd100, -16'sd100);
    push(16'sd200, -16'sd200);
    push(16'sd300, -16'sd300);
    n_vec++; if (level !== 7'd3) begin n_err++; $display("FAIL basic_level got=%0d exp=3", level); end
    for (int k = 0; k < 3; k++) begin
      ei = 16'(100 * (k + 1));
      pop();
      n_vec++; if (out_valid !== 1'b1 || out_I !== ei || out_Q !== -ei) begin
        n_err++; $display("FAIL basic_pop%0d got v=%b I=%0d Q=%0d exp v=1 I=%0d Q=%0d", k, out_valid, out_I, out_Q, ei, -ei); end
      n_vec++; if (level !== 7'(2 - k)) begin n_err++; $display("FAIL basic_lvl%0d got=%0d exp=%0d", k, level, 2 - k); end
      idle(1);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse%0d got=%b exp=0", k, out_valid); end
    end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL basic_empty got=%b exp=1", empty); end
  endtask

  task automatic test_overflow();
    for (int n = 0; n < 64; n++) push(16'(n), -16'(n));
    n_vec++; if (full !== 1'b1 || level !== 7'd64) begin
      n_err++; $display("FAIL ovf_full got f=%b lvl=%0d exp f=1 lvl=64", full, level); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    for (int k = 0; k < 5; k++) push(16'(1000 + k), 16'sd0);
    n_vec++; if (overflow !== 1'b1 || drop_cnt !== 8'd5 || level !== 7'd64) begin
      n_err++; $display("FAIL ovf_drop got o=%b d=%0d lvl=%0d exp o=1 d=5 lvl=64", overflow, drop_cnt, level); end
    for (int n = 0; n < 64; n++) begin
      pop();
      n_vec++; if (out_valid !== 1'b1 || out_I !== 16'(n) || out_Q !== -16'(n)) begin
        n_err++; $display("FAIL ovf_drain%0d got v=%b I=%0d Q=%0d exp v=1 I=%0d Q=%0d", n, out_valid, out_I, out_Q, n, -n); end
    end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty got=%b exp=1", empty); end
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 64; n++) push(16'(n), -16'(n));
    for (int k = 0; k < 300; k++) push(16'sd1, 16'sd1);
    n_vec++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL sat_cnt got=%0d exp=255", drop_cnt); end
    pulse_clear();
    n_vec++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      n_err++; $display("FAIL sat_clear got o=%b d=%0d exp o=0 d=0", overflow, drop_cnt); end
    flag_clear = 1'b1;
    push(16'sd2, 16'sd2);
    flag_clear = 1'b0;
    n_vec++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      n_err++; $display("FAIL sat_clear_vs_drop got o=%b d=%0d exp o=1 d=1", overflow, drop_cnt); end
    flush = 1'b1; idle(1); flush = 1'b0;
    n_vec++; if (level !== 7'd0 || empty !== 1'b1 || overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      n_err++; $display("FAIL sat_flush got lvl=%0d e=%b o=%b d=%0d exp 0/1/1/1", level, empty, overflow, drop_cnt); end
    pulse_clear();
  endtask

  task automatic test_underflow();
    pop();
    n_vec++; if (underflow !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL unf_flag got u=%b v=%b exp u=1 v=0", underflow, out_valid); end
    n_vec++; if (out_I !== 16'sd63 || out_Q !== -16'sd63 || level !== 7'd0) begin
      n_err++; $display("FAIL unf_hold got I=%0d Q=%0d lvl=%0d exp I=63 Q=-63 lvl=0", out_I, out_Q, level); end
    pulse_clear();
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL unf_clear got=%b exp=0", underflow); end
    push_pop(16'sd7, -16'sd7);
    n_vec++; if (level !== 7'd1 || underflow !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL unf_simul got lvl=%0d u=%b v=%b exp lvl=1 u=1 v=0", level, underflow, out_valid); end
    pop();
    n_vec++; if (out_valid !== 1'b1 || out_I !== 16'sd7 || out_Q !== -16'sd7 || level !== 7'd0) begin
      n_err++; $display("FAIL unf_next got v=%b I=%0d Q=%0d lvl=%0d exp v=1 I=7 Q=-7 lvl=0", out_valid, out_I, out_Q, level); end
    pulse_clear();
  endtask

  task automatic test_full_simul();
    for (int n = 0; n < 64; n++) push(16'(500 + n), 16'(n));
    push_pop(16'sd999, -16'sd999);
    n_vec++; if (out_valid !== 1'b1 || out_I !== 16'sd500 || out_Q !== 16'sd0) begin
      n_err++; $display("FAIL fs_out got v=%b I=%0d Q=%0d exp v=1 I=500 Q=0", out_valid, out_I, out_Q); end
    n_vec++; if (level !== 7'd64 || full !== 1'b1 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL fs_state got lvl=%0d f=%b d=%0d o=%b exp 64/1/0/0", level, full, drop_cnt, overflow); end
    for (int k = 0; k < 64; k++) begin
      pop();
      if (k < 63) begin
        n_vec++; if (out_I !== 16'(501 + k) || out_Q !== 16'(k + 1)) begin
          n_err++; $display("FAIL fs_drain%0d got I=%0d Q=%0d exp I=%0d Q=%0d", k, out_I, out_Q, 501 + k, k + 1); end
      end else begin
        n_vec++; if (out_I !== 16'sd999 || out_Q !== -16'sd999) begin
          n_err++; $display("FAIL fs_last got I=%0d Q=%0d exp I=999 Q=-999", out_I, out_Q); end
      end
    end
  endtask

  task automatic test_ready_flush();
    for (int n = 0; n < 15; n++) push(16'(n), 16'(n));
    n_vec++; if (data_ready !== 1'b0 || level !== 7'd15) begin
      n_err++; $display("FAIL rdy_15 got r=%b lvl=%0d exp r=0 lvl=15", data_ready, level); end
    push(16'sd15, 16'sd15);
    n_vec++; if (data_ready !== 1'b1 || level !== 7'd16) begin
      n_err++; $display("FAIL rdy_16 got r=%b lvl=%0d exp r=1 lvl=16", data_ready, level); end
    flush = 1'b1;
    push_pop(16'sd77, 16'sd77);
    flush = 1'b0;
    n_vec++; if (level !== 7'd0 || data_ready !== 1'b0 || empty !== 1'b1) begin
      n_err++; $display("FAIL flush_lvl got lvl=%0d r=%b e=%b exp 0/0/1", level, data_ready, empty); end
    n_vec++; if (drop_cnt !== 8'd0 || underflow !== 1'b0 || out_valid !== 1'b0 || out_I !== 16'sd999) begin
      n_err++; $display("FAIL flush_side got d=%0d u=%b v=%b I=%0d exp 0/0/0/999", drop_cnt, underflow, out_valid, out_I); end
    push(16'sd42, -16'sd42);
    pop();
    n_vec++; if (out_I !== 16'sd42 || out_Q !== -16'sd42) begin
      n_err++; $display("FAIL flush_after got I=%0d Q=%0d exp I=42 Q=-42", out_I, out_Q); end
  endtask

  task automatic test_async_reset();
    for (int n = 0; n < 65; n++) push(16'(n + 1), 16'(n + 2));
    rd_req = 1'b1;
    @(posedge clk_in); #1;
    n_vec++; if (out_valid !== 1'b1 || out_I !== 16'sd1 || overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      n_err++; $display("FAIL ares_pre got v=%b I=%0d o=%b d=%0d exp 1/1/1/1", out_valid, out_I, overflow, drop_cnt); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_I !== 16'sd0 || out_Q !== 16'sd0 || level !== 7'd0) begin
      n_err++; $display("FAIL ares_data got v=%b I=%0d Q=%0d lvl=%0d exp all 0", out_valid, out_I, out_Q, level); end
    n_vec++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || drop_cnt !== 8'd0) begin
      n_err++; $display("FAIL ares_flags got e=%b f=%b o=%b u=%b d=%0d exp 1/0/0/0/0", empty, full, overflow, underflow, drop_cnt); end
    rd_req = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_saturate();
    test_underflow();
    test_full_simul();
    test_ready_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
